// File: rtl/addr_pkg.sv
// Shared encodings for the coefficient address sequencer and its controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package addr_pkg;

    localparam logic [1:0] MODE_DECODE   = 2'd0;
    localparam logic [1:0] MODE_ENCODE   = 2'd1;
    localparam logic [1:0] MODE_STANDARD = 2'd2;
    localparam logic [1:0] MODE_BITREV   = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/addr_permute.sv
// Maps a linear coefficient index to a RAM address using the selected bit permutation.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows inputs.
module addr_permute
    import addr_pkg::*;
#(
    parameter int AW  = 6,
    parameter int ROT = 2
) (
    input  logic [1:0]    mode,
    input  logic [AW-1:0] idx,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] rot_l;
    logic [AW-1:0] rot_r;
    logic [AW-1:0] rev;

    assign rot_l = {idx[AW-1-ROT:0], idx[AW-1:AW-ROT]};
    assign rot_r = {idx[ROT-1:0], idx[AW-1:ROT]};

    // Full-width bit reversal: output bit i takes index bit AW-1-i.
    always_comb begin
        rev = '0;
        for (int i = 0; i < AW; i++) begin
            rev[i] = idx[AW-1-i];
        end
    end

    // Select the permutation for the requested transfer order.
    always_comb begin
        addr = idx;
        case (mode)
            MODE_DECODE:   addr = rot_l;
            MODE_ENCODE:   addr = rot_r;
            MODE_STANDARD: addr = idx;
            MODE_BITREV:   addr = rev;
            default:       addr = idx;
        endcase
    end

endmodule

// File: rtl/addr_sequencer.sv
// Sweeps index 0..len and emits permuted RAM addresses, one per accepted handshake.
// Latency: start in cycle t gives the first valid address in t+1; one address per cycle at full rate.
// Backpressure: addr/last/addr_valid hold while addr_ready is low; valid is never withdrawn.
module addr_sequencer
    import addr_pkg::*;
#(
    parameter int AW  = 6,
    parameter int ROT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic          last,
    output logic          busy,
    output logic          done
);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] len_q;
    logic [1:0]    mode_q;
    logic [AW-1:0] addr_q;
    logic          vld_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;

    logic [1:0]    perm_mode;
    logic [AW-1:0] perm_idx;
    logic [AW-1:0] addr_d;
    logic          accept;

    // In IDLE the permuter sees the incoming mode and index 0 so the first
    // address can be loaded on the start cycle; in RUN it sees the latched mode.
    assign perm_mode = (state_q == IDLE) ? mode : mode_q;
    assign perm_idx  = (state_q == IDLE) ? '0   : cnt_q;
    assign accept    = vld_q & addr_ready;

    addr_permute #(
        .AW  (AW),
        .ROT (ROT)
    ) u_permute (
        .mode (perm_mode),
        .idx  (perm_idx),
        .addr (addr_d)
    );

    // Sweep FSM with registered outputs; done is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        len_q   <= len;
                        cnt_q   <= {{(AW-1){1'b0}}, 1'b1};
                        addr_q  <= addr_d;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= (len == '0);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_q) begin
                            addr_q  <= '0;
                            vld_q   <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            // Counter may wrap at full depth; it is unused once last is set.
                            addr_q <= addr_d;
                            last_q <= (cnt_q == len_q);
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr       = addr_q;
    assign addr_valid = vld_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed self-checking bench for the address sequencer.
// Latency: checks outputs 1ns after each rising edge.
// Backpressure: exercises addr_ready stalls mid-sweep.
module tb_addr_sequencer;

    localparam int AW  = 6;
    localparam int ROT = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] len;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready;
    logic          last;
    logic          busy;
    logic          done;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [1:0]    mode;
        logic [AW-1:0] len;
        logic [AW-1:0] exp_addr [4];
    } vec_t;

    vec_t vecs [4];

    addr_sequencer #(
        .AW  (AW),
        .ROT (ROT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [AW-1:0] l);
        start = 1'b1;
        mode  = m;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic expect_beat(input string name, input logic [AW-1:0] a, input logic l);
        chk({name, ".valid"}, {31'd0, addr_valid}, 32'd1);
        chk({name, ".addr"},  {26'd0, addr},       {26'd0, a});
        chk({name, ".last"},  {31'd0, last},       {31'd0, l});
        chk({name, ".busy"},  {31'd0, busy},       32'd1);
    endtask

    task automatic expect_end(input string name);
        chk({name, ".done"},  {31'd0, done},       32'd1);
        chk({name, ".busy"},  {31'd0, busy},       32'd0);
        chk({name, ".valid"}, {31'd0, addr_valid}, 32'd0);
        chk({name, ".last"},  {31'd0, last},       32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        len        = '0;
        addr_ready = 1'b0;

        vecs[0] = '{mode: 2'd0, len: 6'd3, exp_addr: '{6'd0, 6'd4,  6'd8,  6'd12}};
        vecs[1] = '{mode: 2'd1, len: 6'd3, exp_addr: '{6'd0, 6'd16, 6'd32, 6'd48}};
        vecs[2] = '{mode: 2'd3, len: 6'd3, exp_addr: '{6'd0, 6'd32, 6'd16, 6'd48}};
        vecs[3] = '{mode: 2'd2, len: 6'd3, exp_addr: '{6'd0, 6'd1,  6'd2,  6'd3}};

        step();
        step();
        chk("rst.addr",  {26'd0, addr},       32'd0);
        chk("rst.valid", {31'd0, addr_valid}, 32'd0);
        chk("rst.last",  {31'd0, last},       32'd0);
        chk("rst.busy",  {31'd0, busy},       32'd0);
        chk("rst.done",  {31'd0, done},       32'd0);
        rst = 1'b0;
        step();

        // Short sweeps in every permutation, full rate.
        addr_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].mode, vecs[v].len);
            for (int i = 0; i < 4; i++) begin
                expect_beat($sformatf("vec%0d.b%0d", v, i), vecs[v].exp_addr[i], (i == 3));
                step();
            end
            expect_end($sformatf("vec%0d.end", v));
            step();
            chk($sformatf("vec%0d.done_pulse", v), {31'd0, done}, 32'd0);
        end

        // Full-depth STANDARD sweep, exercises counter wrap.
        do_start(2'd2, 6'd63);
        for (int i = 0; i < 64; i++) begin
            expect_beat($sformatf("full.b%0d", i), i[AW-1:0], (i == 63));
            step();
        end
        expect_end("full.end");
        step();
        chk("full.idle_busy", {31'd0, busy}, 32'd0);
        chk("full.idle_done", {31'd0, done}, 32'd0);

        // Backpressure: stall while addr=4.
        do_start(2'd0, 6'd3);
        expect_beat("bp.b0", 6'd0, 1'b0);
        step();
        addr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_beat($sformatf("bp.stall%0d", k), 6'd4, 1'b0);
        end
        addr_ready = 1'b1;
        step();
        expect_beat("bp.b2", 6'd8, 1'b0);
        step();
        expect_beat("bp.b3", 6'd12, 1'b1);
        step();
        expect_end("bp.end");

        // len=0, then a new start accepted in the done cycle.
        step();
        do_start(2'd2, 6'd0);
        expect_beat("len0.b0", 6'd0, 1'b1);
        step();
        expect_end("len0.end");
        do_start(2'd2, 6'd1);
        chk("b2b.done_drop", {31'd0, done}, 32'd0);
        expect_beat("b2b.b0", 6'd0, 1'b0);
        step();
        expect_beat("b2b.b1", 6'd1, 1'b1);
        step();
        expect_end("b2b.end");
        step();

        // Start while busy is ignored; mode input change has no effect.
        do_start(2'd2, 6'd7);
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("ign.b%0d", i), i[AW-1:0], (i == 7));
            if (i == 2) begin
                start = 1'b1;
                mode  = 2'd3;
                len   = 6'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        expect_end("ign.end");
        step();

        // Reset mid-sweep at addr=5 aborts without a done pulse.
        do_start(2'd2, 6'd15);
        for (int i = 0; i < 5; i++) step();
        expect_beat("rstmid.b5", 6'd5, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.valid", {31'd0, addr_valid}, 32'd0);
        chk("rstmid.busy",  {31'd0, busy},       32'd0);
        chk("rstmid.addr",  {26'd0, addr},       32'd0);
        chk("rstmid.done",  {31'd0, done},       32'd0);
        step();
        chk("rstmid.done2", {31'd0, done},       32'd0);
        chk("rstmid.idle_valid", {31'd0, addr_valid}, 32'd0);
        do_start(2'd0, 6'd3);
        expect_beat("fresh.b0", 6'd0, 1'b0);
        step();
        expect_beat("fresh.b1", 6'd4, 1'b0);
        step();
        step();
        expect_beat("fresh.b3", 6'd12, 1'b1);
        step();
        expect_end("fresh.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Parametrised successor to the coefficient address remapping logic.
- Walks a linear index from 0 to a programmable limit and applies a selectable bit-permutation to each index.
- Emits the mapped addresses one per accepted handshake, to drive polynomial RAM reads/writes during encode, decode and NTT-order transfers.
- Sits between the top-level controller, which issues start/mode/len, and a RAM port or packer, which consumes addr under valid/ready.

Parameters:
- AW, 6, index/address width in bits; polynomial depth 2^AW.
- ROT, 2, rotation amount for the DECODE/ENCODE modes; legal range 1..AW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- mode  in  2  0=DECODE (rotate left by ROT), 1=ENCODE (rotate right by ROT), 2=STANDARD (identity), 3=BITREV (full AW-bit reversal). Latched on start.
- len  in  AW  index of the final element; sweep covers 0..len inclusive. Latched on start.
- addr  out  AW  mapped address (registered).
- addr_valid  out  1  addr holds a valid address.
- addr_ready  in  1  consumer accepts addr when addr_valid && addr_ready.
- last  out  1  high together with addr_valid on the final address of the sweep.
- busy  out  1  high from the cycle after an accepted start through the final handshake.
- done  out  1  one-cycle pulse in the cycle after the final handshake.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; latched mode/len 0. rst has priority over every other input, including mid-sweep; it aborts the sweep with no done pulse.
- FSM IDLE:
  - If start is high: latch mode and len, set counter to 1, load addr=perm(0), assert addr_valid and busy, set last=(len==0), go to RUN.
  - Otherwise all outputs hold 0, except that done may be high for exactly this one cycle after a sweep.
- FSM RUN:
  - On handshake when last=0: addr <= perm(counter), last <= (counter==len), counter increments.
  - On handshake when last=1: clear addr_valid, last and busy; assert done for the next cycle; return to IDLE.
  - Without a handshake: addr, last and addr_valid hold stable. Never withdraw valid.
- Latency: start in cycle t gives the first addr_valid in cycle t+1. Throughput is one address per cycle while addr_ready=1.
- start while busy is ignored; the latched mode/len are unaffected.
- start is accepted in the same cycle done is high; done still pulses and the new sweep's first address appears the following cycle.
- perm is purely combinational on the counter:
  - DECODE: {idx[AW-1-ROT:0], idx[AW-1:AW-ROT]}.
  - ENCODE: {idx[ROT-1:0], idx[AW-1:ROT]}.
  - BITREV: idx[0]..idx[AW-1] (bit reversal).
  - STANDARD: idx.
- Counter width is AW bits. When len=2^AW-1, the counter wraps to 0 after the final load; this is harmless because it is unused after last.
- Mode changes mid-sweep have no effect.

Decomposition:
- Package addr_pkg: mode localparams MODE_DECODE=0, MODE_ENCODE=1, MODE_STANDARD=2, MODE_BITREV=3, and FSM state encodings IDLE=0, RUN=1. The package is shared with the controller.
- One combinational sub-module, addr_permute (params AW, ROT; in mode, idx; out addr), instantiated once on the counter path.

Test Plan:
- STANDARD, len=63, addr_ready=1 -> addr 0..63 on 64 consecutive cycles starting at t+1; last only with 63; done pulses on the cycle after; busy low afterwards.
- DECODE, len=3 -> addr 0,4,8,12. ENCODE, len=3 -> addr 0,16,32,48. BITREV, len=3 -> addr 0,32,16,48. In each case last is high on the 4th address.
- Backpressure: DECODE, len=3, addr_ready low for 3 cycles while addr=4 -> addr stays 4 with addr_valid high throughout; the sequence then resumes 8,12 with no skip or duplicate.
- len=0, STANDARD -> a single addr=0 with last=1 at t+1; done at t+2 once it is accepted.
- Second start with mode=BITREV mid-sweep of a STANDARD run -> ignored; STANDARD sequence completes unchanged.
- rst asserted mid-sweep at addr=5 -> the next cycle shows addr_valid=0, busy=0, addr=0, no done; a fresh start afterwards begins at 0.
